// File: rtl/seg7_pkg.sv
// Shared constants for the eight-digit seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the pattern for hex digit n; entry 15 sits in the top slice.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed eight-digit hex display driver with frame-aligned updates.
// New data waits in a shadow register and is promoted only at the 7->0 digit wrap.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  dp_in,
  input  logic        blank_lead,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending,
  output logic        frame_done
);

  localparam logic [31:0] LAST_COUNT = 32'(SCAN_DIV - 1);

  logic [31:0] presc;
  logic [2:0]  idx;
  logic        tick;
  logic        boundary;

  logic [31:0] shadow_data;
  logic [7:0]  shadow_dp;
  logic [31:0] disp_data;
  logic [7:0]  disp_dp;

  logic [3:0]  cur_nibble;
  logic [6:0]  cur_seg;
  logic [31:0] upper_nibbles;
  logic        blank;

  assign tick     = (presc == LAST_COUNT);
  assign boundary = tick && (idx == 3'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 32'd1;
      if (tick) idx <= idx + 3'd1;
    end
  end

  // A load landing on the wrap edge bypasses the shadow so it is not delayed a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      disp_data   <= '0;
      disp_dp     <= '0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (boundary) begin
        if (load) begin
          disp_data <= data_in;
          disp_dp   <= dp_in;
        end else if (pending) begin
          disp_data <= shadow_data;
          disp_dp   <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
        pending     <= 1'b1;
      end
    end
  end

  assign cur_nibble    = disp_data[{idx, 2'b00} +: 4];
  assign upper_nibbles = disp_data >> {idx, 2'b00};
  assign blank         = blank_lead && (idx != 3'd0) && (upper_nibbles == 32'd0);

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (blank) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'd1 << idx);
      seg <= cur_seg;
      dp  <= ~disp_dp[idx];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver with a queue-based scoreboard.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  dp_in;
  logic        blank_lead;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        frame_done;

  seg7_scan_driver #(.SCAN_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .dp_in      (dp_in),
    .blank_lead (blank_lead),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       pend;
  } exp_t;

  exp_t expq[$];

  int nerr = 0;
  int nchk = 0;

  logic [6:0] ref_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: time since reset determines the digit shown.
  int          mt;
  int          md;
  bit          mbnd;
  bit          mlit;
  logic [31:0] mdisp, msh;
  logic [7:0]  mdp, mshdp;
  bit          mpend;
  exp_t        me;

  always @(posedge clk) begin
    if (rst) begin
      mt = 0; mdisp = 0; mdp = 0; msh = 0; mshdp = 0; mpend = 0;
      me = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fd: 1'b0, pend: 1'b0};
    end else begin
      md   = (mt / DIV) % 8;
      mbnd = (mt % FRAME) == FRAME - 1;
      mlit = !(blank_lead && md != 0 && (mdisp >> (4 * md)) == 0);
      me.an  = mlit ? ~(8'd1 << md) : 8'hFF;
      me.seg = mlit ? ref_seg[(mdisp >> (4 * md)) & 32'hF] : 7'h7F;
      me.dp  = mlit ? !mdp[md] : 1'b1;
      me.fd  = mbnd;
      if (mbnd) begin
        if (load) begin mdisp = data_in; mdp = dp_in; end
        else if (mpend) begin mdisp = msh; mdp = mshdp; end
        mpend = 0;
      end else if (load) begin
        msh = data_in; mshdp = dp_in; mpend = 1;
      end
      me.pend = mpend;
      mt++;
    end
    expq.push_back(me);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  exp_t ce;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      ce = expq.pop_front();
      chk("an",         32'(an),         32'(ce.an));
      chk("seg",        32'(seg),        32'(ce.seg));
      chk("dp",         32'(dp),         32'(ce.dp));
      chk("frame_done", 32'(frame_done), 32'(ce.fd));
      chk("pending",    32'(pending),    32'(ce.pend));
    end
  end

  task automatic load_word(input logic [31:0] d, input logic [7:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while ((mt % FRAME) != ph && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if ((mt % FRAME) != ph) begin
      nchk++;
      nerr++;
      $display("FAIL wait_phase: phase %0d expected %0d", mt % FRAME, ph);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; blank_lead = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Mid-frame load with leading-zero blanking.
    wait_phase(12);
    blank_lead = 1'b1;
    load_word(32'h0000_00A5, 8'h00);
    repeat (50) @(negedge clk);

    // Two loads in one frame: last one wins.
    wait_phase(4);
    load_word(32'h1111_1111, 8'h00);
    repeat (5) @(negedge clk);
    load_word(32'h2222_2222, 8'h00);
    repeat (40) @(negedge clk);

    // Load exactly on the wrap edge.
    wait_phase(FRAME - 1);
    load_word(32'hFFFF_FFFF, 8'h00);
    repeat (40) @(negedge clk);

    // Decimal point on digit 2, then blanking switched on live with zero data.
    blank_lead = 1'b0;
    wait_phase(0);
    load_word(32'h0000_0000, 8'h04);
    repeat (40) @(negedge clk);
    wait_phase(9);
    blank_lead = 1'b1;
    repeat (40) @(negedge clk);

    // Reset while a load is pending at digit 5.
    blank_lead = 1'b0;
    wait_phase(2);
    load_word(32'h1234_5678, 8'hFF);
    wait_phase(21);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      load    = ($urandom_range(0, 11) == 0);
      data_in = $urandom() >> $urandom_range(0, 32);
      dp_in   = 8'($urandom());
      if ($urandom_range(0, 49) == 0) blank_lead = ~blank_lead;
      rst     = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    load = 1'b0;
    rst  = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100_000, meaning clk cycles each digit stays lit; legal range 2..2^31-1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port data_in, input, 32 bits: eight hex nibbles; nibble i drives digit i, with digit 0 as the LSB nibble.
REQ-005 The block SHALL have port load, input, 1 bit: a 1-cycle strobe that captures data_in and dp_in.
REQ-006 The block SHALL have port dp_in, input, 8 bits: decimal-point request per digit, active-high.
REQ-007 The block SHALL have port blank_lead, input, 1 bit: enables leading-zero blanking; it is sampled live.
REQ-008 The block SHALL have port an, output, 8 bits: digit anodes, active-low, one-hot-low when lit.
REQ-009 The block SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 The block SHALL have port dp, output, 1 bit: decimal point, active-low.
REQ-011 The block SHALL have port pending, output, 1 bit: set when a loaded value is waiting for a frame boundary.
REQ-012 The block SHALL have port frame_done, output, 1 bit: a 1-cycle pulse at the end of each 8-digit frame.

Function
REQ-013 The prescaler SHALL count 0..SCAN_DIV-1 and assert internal tick for the cycle where count==SCAN_DIV-1; count then returns to 0.
REQ-014 The digit index (3 bits) SHALL increment on each tick and wrap from 7 to 0.
REQ-015 frame_done SHALL pulse, registered, in the cycle after the tick taken while index==7.
REQ-016 On load, data_in and dp_in SHALL be written to a shadow register and pending set to 1.
REQ-017 A load while pending=1 SHALL overwrite the shadow; the last load wins.
REQ-018 On the tick at index 7→0 with pending=1, shadow SHALL copy to the display register and pending SHALL clear in the same edge.
REQ-019 If load coincides with the 7→0 tick, the display register SHALL take the new data_in/dp_in directly and pending SHALL stay 0.
REQ-020 Display-register changes SHALL occur only at frame boundaries; no frame may show mixed old/new digits.
REQ-021 an, seg and dp SHALL be registered and reflect the current index and display register with 1-cycle latency.
REQ-022 Digit i (i>0) SHALL be blanked (an bit high, seg=7'h7F, dp=1) when blank_lead=1 and nibbles i..7 are all zero.
REQ-023 Digit 0 SHALL never be blanked.
REQ-024 seg decode (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-025 dp SHALL equal ~dp_reg[index] for lit digits.

Reset
REQ-026 On rst=1 at a clock edge: prescaler=0, index=0, shadow=0, display=0, pending=0, frame_done=0.
REQ-027 During reset, an=8'hFF, seg=7'h7F and dp=1.
REQ-028 The first cycle after rst deasserts SHALL output an=8'hFE and seg=7'h40 (digit 0 shows "0").
REQ-029 rst asserted mid-frame or with pending=1 SHALL discard the shadow and restart at digit 0 with no frame_done pulse.

Structure
REQ-030 Package seg7_pkg SHALL hold NUM_DIGITS=8, the 16-entry active-low decode table and the blank-pattern constant 7'h7F.
REQ-031 Combinational sub-module seg7_hex_decode (4-bit nibble → 7-bit seg, using seg7_pkg) SHALL be instantiated once.

Verification (SCAN_DIV=4 unless stated)
REQ-032 Reset then run 40 cycles with load=0 → an sequence FE,FD,FB,...,7F, each held 4 cycles; seg=40 throughout; frame_done pulses every 32 cycles.
REQ-033 load data_in=32'h0000_00A5, blank_lead=1 mid-frame → display changes only after the next 7→0 tick; digit0 seg=12, digit1 seg=08, digits 2..7 an bit high.
REQ-034 Two loads in one frame (32'h11111111 then 32'h22222222) → only 22222222 appears (seg=24 on all digits); pending falls at the boundary.
REQ-035 load coincident with the 7→0 tick, data_in=32'hFFFF_FFFF → every digit of the new frame shows seg=0E; pending never rises.
REQ-036 dp_in=8'h04 loaded → dp=0 only while an=FB; blank_lead toggled 0→1 with data 0 → digits 1..7 go dark immediately (1-cycle latency).
REQ-037 rst pulsed while pending=1 at index 5 → an=FF in the reset cycle, then FE, display=0, pending=0.
